// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: rebuilds WIDTH-bit words from a start-marked serial
// stream and hands them out through a single-entry valid/ready holding register.
module sipo_deframer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_in,
  input  logic             start,
  input  logic             p_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;

  logic             capture;
  logic             restart;
  logic             last;
  logic [CW-1:0]    bit_idx;
  logic [WIDTH-1:0] word;

  // A start always begins a fresh frame, even mid-word, so the partial word is dropped.
  always_comb begin
    capture = start || (state == SHIFT);
    restart = start && (state == SHIFT);
    bit_idx = start ? '0 : cnt;
    last    = capture && (bit_idx == CW'(WIDTH - 1));
    word    = start ? '0 : shreg;
    for (int i = 0; i < WIDTH; i++) begin
      if ((MSB_FIRST ? (WIDTH - 1 - i) : i) == int'(bit_idx)) begin
        word[i] = s_in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      p_out     <= '0;
      p_valid   <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (err_clr) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (restart) begin
        frame_err <= 1'b1;
      end

      if (capture) begin
        shreg <= word;
        if (last) begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end else begin
          state <= SHIFT;
          busy  <= 1'b1;
          cnt   <= bit_idx + 1'b1;
        end
      end

      // The holding register is free if empty or being drained on this same edge.
      if (last && (!p_valid || p_ready)) begin
        p_out   <= word;
        p_valid <= 1'b1;
      end else begin
        if (last) begin
          overrun <= 1'b1;
        end
        if (p_valid && p_ready) begin
          p_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
- Receive-side partner of the 4-bit parallel-in/serial-out shifter. Consumes its serial stream, which is MSB-first and idles high after a word has shifted out.
- A `start` strobe marks the first bit of each word. The block reassembles WIDTH-bit words and presents them on a registered parallel output with a valid/ready handshake.
- Raises sticky error flags for lost words (overrun) and truncated frames.

Parameters:
- WIDTH, 4, word length in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1:
  - 1 = first received bit lands in p_out[WIDTH-1].
  - 0 = first received bit lands in p_out[0].

Ports:
- clk  input  1  single rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- s_in  input  1  serial data, sampled every rising clk edge.
- start  input  1  high in the same cycle as the first bit of a word on s_in.
- p_ready  input  1  downstream accepts p_out in any cycle where p_valid && p_ready.
- err_clr  input  1  synchronous clear of overrun and frame_err.
- p_out  output  WIDTH  assembled word, held stable while p_valid=1.
- p_valid  output  1  holding register contains an unconsumed word.
- busy  output  1  a word is partially received (state SHIFT).
- overrun  output  1  sticky: a completed word was dropped.
- frame_err  output  1  sticky: a start arrived before the previous word completed.

Behaviour:
- Reset (async, reset=1): state=IDLE, bit counter=0, shift register=0, p_out=0, p_valid=0, busy=0, overrun=0, frame_err=0. Release is taken at the first clk edge with reset=0.
- States:
  - IDLE: start=1 → capture s_in as bit 0, counter=1, go to SHIFT. start=0 → stay; s_in is ignored.
  - SHIFT: capture s_in each edge and increment the counter. When the captured bit is bit WIDTH-1, the word is complete → go to IDLE.
- Restart: start=1 while in SHIFT →
  - discard the partial word;
  - set frame_err;
  - treat this s_in as bit 0 of a new word (counter=1, stay in SHIFT).
- Bit placement: bit k of the frame goes to index WIDTH-1-k (MSB_FIRST=1) or index k (MSB_FIRST=0).
- Completion:
  - At the edge capturing bit WIDTH-1, the full word is written to p_out and p_valid=1 if the holding register is free. Free means p_valid=0, or p_valid && p_ready in that same cycle.
  - Latency: p_out and p_valid are valid in the cycle after the edge that sampled the last bit.
- Overrun: on completion with p_valid=1 and p_ready=0 →
  - the new word is dropped;
  - p_out keeps the old word;
  - overrun=1.
- Handshake:
  - p_valid falls on the edge where p_valid && p_ready, unless a new word completes on that same edge. In that case p_out takes the new word and p_valid stays 1.
  - p_out never changes while p_valid=1 && p_ready=0.
- Back-to-back: start may be asserted in the cycle immediately after the last bit (state IDLE). This gives zero-gap streaming of one word every WIDTH cycles, matching an upstream shifter reloaded every WIDTH cycles.
- busy = (state==SHIFT). It is registered and glitch-free.
- Sticky flags:
  - cleared only by reset or by err_clr=1 at an edge;
  - if a set event and err_clr occur on the same edge, the set wins.
- Reset asserted mid-word: immediately returns all state to the reset values; the partial word is lost and no flag is raised.
- The counter width is clog2(WIDTH)+1; it never wraps in normal operation.

Test Plan:
- Single word, WIDTH=4, MSB_FIRST=1: start=1 with s_in 1, then s_in 0,1,1 → p_out=4'b1011, p_valid=1 in the cycle after the 4th edge; busy=1 for cycles 2–4.
- Back-to-back 4'hA then 4'h5 with p_ready=1 permanently → p_valid high for exactly two consecutive word slots, p_out=4'hA then 4'h5; overrun=0.
- Overrun: p_ready=0, send 4'h3 then 4'hC → p_out stays 4'h3, overrun=1. Then p_ready=1 for one cycle → p_valid=0. Then err_clr=1 → overrun=0.
- Restart: start, 2 bits of 1,1, then start with s_in 0,0,1,0 → frame_err=1, p_out=4'b0010; no word is emitted for the truncated frame.
- Accept and complete on the same edge: p_valid=1 holding 4'h9, p_ready=1 on the edge capturing the last bit of 4'h6 → p_out=4'h6, p_valid stays 1, overrun=0.
- Async reset mid-word: assert reset between clk edges after 2 bits → outputs are 0 immediately. Then a full new word 4'hF decodes correctly; MSB_FIRST=0 with the same stimulus → 4'hF.
